pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Sequences the fetch stage through boot, run and halt.
- Merges jump requests (EX) and stall requests (ID load-use, MEM busy) into a single jump flag/address and hold-flag code, which drive the PC register and the pipeline registers.
- Owns the reboot pulse and a debug halt/resume handshake.

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage core pipeline sequencer: boot/run/halt, jump and hold-flag merge (optional PIPE_CTRL_PERF_EN perf counters)
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int HOLD_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reboot_req_i,
  input  logic              jump_req_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              id_stall_i,
  input  logic              mem_busy_i,
  input  logic              halt_req_i,
  output logic              halt_ack_o,
  output logic              reboot_o,
  output logic              jump_flag_o,
  output logic [31:0]       jump_addr_o,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       jump_cnt_o
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_PC   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_IF   = HOLD_W'(2);
  localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [7:0]        r_boot_cnt;
  logic              r_halt_ack;
  logic [1:0]        w_next_state;
  logic [7:0]        w_next_boot_cnt;
  logic              w_jump_flag;
  logic [31:0]       w_jump_addr;
  logic [HOLD_W-1:0] w_hold_flag;
  logic              w_reboot;

  // Output decode: same-cycle response to jump and stall requests
  always_comb begin
    w_reboot    = 1'b0;
    w_jump_flag = 1'b0;
    w_jump_addr = 32'd0;
    w_hold_flag = HOLD_NONE;
    case (r_state)
      ST_BOOT: begin
        w_reboot    = 1'b1;
        w_hold_flag = HOLD_ID;
      end
      ST_RUN: begin
        // MEM busy defers any jump; EX keeps presenting it while ID/EX is held
        if (mem_busy_i) begin
          w_hold_flag = HOLD_ID;
        end else if (jump_req_i) begin
          w_jump_flag = 1'b1;
          w_jump_addr = jump_addr_i;
          w_hold_flag = HOLD_ID;
        end else if (id_stall_i) begin
          w_hold_flag = HOLD_IF;
        end
      end
      ST_HALT: begin
        w_hold_flag = HOLD_PC;
      end
      default: begin
        w_reboot    = 1'b1;
        w_hold_flag = HOLD_ID;
      end
    endcase
  end

  // Next-state and boot counter: halt only enters between jumps and MEM accesses
  always_comb begin
    w_next_state    = r_state;
    w_next_boot_cnt = 8'd0;
    case (r_state)
      ST_BOOT: begin
        if (reboot_req_i) begin
          w_next_boot_cnt = 8'd0;
        end else if (r_boot_cnt == BOOT_LAST) begin
          w_next_state    = ST_RUN;
          w_next_boot_cnt = 8'd0;
        end else begin
          w_next_boot_cnt = r_boot_cnt + 8'd1;
        end
      end
      ST_RUN: begin
        if (reboot_req_i) begin
          w_next_state = ST_BOOT;
        end else if (halt_req_i && !mem_busy_i && !jump_req_i) begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: begin
        if (reboot_req_i) begin
          w_next_state = ST_BOOT;
        end else if (!halt_req_i) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  // State, boot counter and registered halt acknowledge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= 8'd0;
      r_halt_ack <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_boot_cnt <= w_next_boot_cnt;
      r_halt_ack <= (w_next_state == ST_HALT);
    end
  end

  assign reboot_o    = w_reboot;
  assign jump_flag_o = w_jump_flag;
  assign jump_addr_o = w_jump_addr;
  assign hold_flag_o = w_hold_flag;
  assign halt_ack_o  = r_halt_ack;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_jump_cnt;
  logic        w_enter_boot;

  assign w_enter_boot = (r_state != ST_BOOT) && (w_next_state == ST_BOOT);

  // Saturating performance counters, cleared whenever fetch reboots
  always_ff @(posedge clk_i) begin
    if (rst_i || w_enter_boot) begin
      r_stall_cnt <= 32'd0;
      r_jump_cnt  <= 32'd0;
    end else begin
      if (r_state == ST_RUN && w_hold_flag != HOLD_NONE && !w_jump_flag &&
          r_stall_cnt != 32'hFFFF_FFFF) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_jump_flag && r_jump_cnt != 32'hFFFF_FFFF) begin
        r_jump_cnt <= r_jump_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign jump_cnt_o  = r_jump_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign jump_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reboot_req_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        id_stall_i;
  logic        mem_busy_i;
  logic        halt_req_i;
  logic        halt_ack_o;
  logic        reboot_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] jump_cnt_o;

  int n_total  = 0;
  int n_passed = 0;

  pipe_ctrl #(.BOOT_CYCLES(4), .HOLD_W(3)) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .reboot_req_i (reboot_req_i),
    .jump_req_i   (jump_req_i),
    .jump_addr_i  (jump_addr_i),
    .id_stall_i   (id_stall_i),
    .mem_busy_i   (mem_busy_i),
    .halt_req_i   (halt_req_i),
    .halt_ack_o   (halt_ack_o),
    .reboot_o     (reboot_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .hold_flag_o  (hold_flag_o),
    .stall_cnt_o  (stall_cnt_o),
    .jump_cnt_o   (jump_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Checks at the falling edge so combinational outputs have settled
  task automatic expect_out(input string tag, input logic rb, input logic jf,
                            input logic [2:0] hold, input logic ack, input logic [31:0] addr);
    @(negedge clk_i);
    check({tag, ".ctl"}, {26'd0, reboot_o, jump_flag_o, hold_flag_o, halt_ack_o},
          {26'd0, rb, jf, hold, ack});
    check({tag, ".addr"}, jump_addr_o, addr);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; reboot_req_i = 1'b0; jump_req_i = 1'b0; jump_addr_i = 32'd0;
    id_stall_i = 1'b0; mem_busy_i = 1'b0; halt_req_i = 1'b0;

    // Reset held for two edges; jump input ignored while booting
    next_cycle();
    jump_req_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF;
    expect_out("rst", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    rst_i = 1'b0; jump_req_i = 1'b0; jump_addr_i = 32'd0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("boot%0d", i), 1, 0, 3'd3, 0, 32'd0);
      next_cycle();
    end
    expect_out("run_idle", 0, 0, 3'd0, 0, 32'd0);

    // Single-cycle jump
    next_cycle();
    jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100;
    expect_out("jump", 0, 1, 3'd3, 0, 32'h100);
    next_cycle();
    jump_req_i = 1'b0; jump_addr_i = 32'd0;
    expect_out("jump_after", 0, 0, 3'd0, 0, 32'd0);

    // Jump deferred behind 3 busy cycles
    next_cycle();
    mem_busy_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("busy%0d", i), 0, 0, 3'd3, 0, 32'd0);
      next_cycle();
    end
    mem_busy_i = 1'b0;
    expect_out("busy_jump", 0, 1, 3'd3, 0, 32'h200);

    // Jump beats ID stall; stall alone holds IF
    next_cycle();
    id_stall_i = 1'b1; jump_addr_i = 32'h0000_0300;
    expect_out("stall_jump", 0, 1, 3'd3, 0, 32'h300);
    next_cycle();
    jump_req_i = 1'b0;
    expect_out("stall", 0, 0, 3'd2, 0, 32'd0);
    next_cycle();
    id_stall_i = 1'b0;

    // Halt waits for MEM busy to drop
    halt_req_i = 1'b1; mem_busy_i = 1'b1;
    expect_out("halt_busy0", 0, 0, 3'd3, 0, 32'd0);
    next_cycle();
    expect_out("halt_busy1", 0, 0, 3'd3, 0, 32'd0);
    next_cycle();
    mem_busy_i = 1'b0;
    expect_out("halt_req", 0, 0, 3'd0, 0, 32'd0);
    next_cycle();
    jump_req_i = 1'b1; jump_addr_i = 32'h0000_0500;
    expect_out("halted", 0, 0, 3'd1, 1, 32'd0);
    next_cycle();
    jump_req_i = 1'b0; halt_req_i = 1'b0;
    expect_out("resume_req", 0, 0, 3'd1, 1, 32'd0);
    next_cycle();
    expect_out("resumed", 0, 0, 3'd0, 0, 32'd0);

    // Halt does not split a jump
    next_cycle();
    halt_req_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0400;
    expect_out("halt_jump", 0, 1, 3'd3, 0, 32'h400);
    next_cycle();
    jump_req_i = 1'b0;
    expect_out("halt_after_jump", 0, 0, 3'd0, 0, 32'd0);
    next_cycle();
    expect_out("halted2", 0, 0, 3'd1, 1, 32'd0);

    // Reboot beats resume in HALT; rst mid-boot restarts the count
    next_cycle();
    reboot_req_i = 1'b1; halt_req_i = 1'b0;
    expect_out("halt_reboot", 0, 0, 3'd1, 1, 32'd0);
    next_cycle();
    reboot_req_i = 1'b0;
    expect_out("reboot0", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    expect_out("reboot1", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    rst_i = 1'b1;
    expect_out("reboot_rst", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("reboot_rst_boot%0d", i), 1, 0, 3'd3, 0, 32'd0);
      next_cycle();
    end
    expect_out("run_after_rst", 0, 0, 3'd0, 0, 32'd0);

    // Reboot from RUN: this cycle's jump still issues; reboot_req in BOOT restarts count
    next_cycle();
    reboot_req_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h0000_0600;
    expect_out("run_reboot_jump", 0, 1, 3'd3, 0, 32'h600);
    next_cycle();
    reboot_req_i = 1'b0; jump_req_i = 1'b0;
    expect_out("rb_boot0", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    reboot_req_i = 1'b1;
    expect_out("rb_boot1", 1, 0, 3'd3, 0, 32'd0);
    next_cycle();
    reboot_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("rb_restart%0d", i), 1, 0, 3'd3, 0, 32'd0);
      next_cycle();
    end
    expect_out("run_final", 0, 0, 3'd0, 0, 32'd0);

    // Counters are tied off in the default build
    check("stall_cnt", stall_cnt_o, 32'd0);
    check("jump_cnt", jump_cnt_o, 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
